control_unit: RTL and testbench
===============================

# control_unit

Multicycle sequencer for the processor datapath. Fetches each instruction through the shared 17-bit bus multiplexer, decodes the opcode held in IR, and steps the bus select, register-load strobes, ALU control and memory strobes through the per-instruction state sequence. It sits between the Run/Done handshake at the top level and the multiplexer, register bank, A/G registers, program counter and memory-address/data registers.

## Interface
- No parameters.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; forces state F0 and drops all strobes immediately.
- CU_Run  in  1  start request; sampled only in F0.
- CU_IR  in  17  instruction register contents:
  - [16:13] opcode
  - [12:10] Rx
  - [2:0] Ry
  - [8:0] immediate
- CU_G_nz  in  1  G register is non-zero; used by MVNZ only.
- CU_MUX_select  out  4  bus multiplexer select:
  - 0001 Rx
  - 0010 Ry
  - 0011 counter
  - 0100 immediate
  - 0101 immediate top
  - 0110 G
  - 0111 DIN
  - 0000 idle
- CU_R_in  out  8  one-hot register-bank write enable, index Rx.
- CU_IR_in, CU_A_in, CU_G_in  out  1 each  register load strobes.
- CU_AddSub  out  1  ALU operation: 0 add, 1 subtract.
- CU_ADDR_in, CU_DOUT_in, CU_W_D  out  1 each  address-register load, data-out load, memory write.
- CU_PC_incr  out  1  counter increment.
- CU_Done  out  1  one-cycle pulse in the final cycle of each instruction.

## Operation
- State register holds F0, F1, F2, E1, E2, E3.
- Outputs are combinational decodes of the state register and CU_IR.
- Any strobe not listed for a state is 0. CU_MUX_select is 0000 where no select is listed.
- Fetch sequence:
  - F0: if CU_Run=1, select 0011 and assert ADDR_in, then go to F1. Otherwise stay in F0 with all outputs 0.
  - F1: assert PC_incr (memory read latency cycle), then go to F2.
  - F2: select 0111 and assert IR_in, then go to E1.
- Opcodes, with strobes per state:
  - 0000 MV: E1 select 0010, R_in[Rx], Done.
  - 0001 MVI: E1 select 0100, R_in[Rx], Done.
  - 0010 MVT: E1 select 0101, R_in[Rx], Done.
  - 0011 ADD / 0100 SUB:
    - E1: select 0001, A_in.
    - E2: select 0010, G_in, AddSub = 0 for ADD, 1 for SUB.
    - E3: select 0110, R_in[Rx], Done.
  - 0101 LD:
    - E1: select 0010, ADDR_in.
    - E2: no strobes (memory read latency).
    - E3: select 0111, R_in[Rx], Done.
  - 0110 ST:
    - E1: select 0010, ADDR_in.
    - E2: select 0001, DOUT_in, W_D, Done.
  - 0111 MVNZ: see Configuration.
  - 1000–1111 invalid: E1 asserts Done only, with no writes.
- After any state that asserts Done, the next state is F0.

## Timing
- Reset values: state F0, CU_MUX_select=0000, all other outputs 0.
- Instruction latency from F0 with Run=1 to the Done cycle, inclusive:
  - 4 cycles: MV, MVI, MVT, MVNZ, invalid.
  - 5 cycles: ST.
  - 6 cycles: ADD, SUB, LD.
- Run is ignored outside F0. Dropping Run mid-instruction does not abort it. Holding Run high issues back-to-back instructions with no idle cycle.
- Reset asserted mid-instruction returns to F0 asynchronously. The partial instruction is discarded and no Done is issued for it.
- CU_IR is stable from the F2→E1 edge onward, because IR_in is only asserted in F2.
- Exactly one bit of CU_R_in is set in any cycle that writes the register bank. R7 is writable like any other register.

## Configuration
- CONTROL_UNIT_MVNZ_EN defined:
  - Opcode 0111 is MVNZ. E1 asserts Done.
  - If CU_G_nz=1, E1 also selects 0010 and asserts R_in[Rx].
  - If CU_G_nz=0, no register write occurs.
- CONTROL_UNIT_MVNZ_EN undefined: opcode 0111 decodes as invalid (Done only). CU_G_nz is unused.

## Test plan
- Reset with Run=0, then hold 5 cycles: all outputs 0, CU_MUX_select=0000, no state change. Then Run=1: F0 select 0011 + ADDR_in; F1 PC_incr; F2 select 0111 + IR_in.
- MVI with Rx=3, imm=9'h005: E1 has select 0100, CU_R_in=8'b00001000, Done; total 4 cycles.
- SUB with Rx=2, Ry=5:
  - E1: select 0001, A_in.
  - E2: select 0010, G_in, AddSub=1.
  - E3: select 0110, CU_R_in=8'b00000100, Done.
- ST with Rx=1, Ry=4, then LD with Rx=6, Ry=4, Run held high:
  - ST: W_D and DOUT_in together in E2.
  - LD: Done in E3 with select 0111, R_in[6].
  - No gap between the two instructions.
- Reset pulsed during E2 of an ADD: strobes drop in the same cycle, no Done, and the next fetch starts from F0.
- Opcode 0111 with Rx=0:
  - With the macro and G_nz=1: R_in[0] is asserted.
  - With the macro and G_nz=0: no write, Done still asserted.
  - Without the macro: Done only.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle sequencer: fetch via the shared bus mux, decode IR, step datapath strobes.
// Latency: 4 cycles (MV/MVI/MVT/MVNZ/invalid), 5 (ST), 6 (ADD/SUB/LD) from Run to Done.
// Backpressure: none; CU_Run is sampled only in F0, and an instruction always runs to completion.
// Optional feature macro: CONTROL_UNIT_MVNZ_EN enables opcode 0111 as MVNZ (conditional move on G != 0).
module control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CU_Run,
  input  logic [16:0] CU_IR,
  input  logic        CU_G_nz,
  output logic [3:0]  CU_MUX_select,
  output logic [7:0]  CU_R_in,
  output logic        CU_IR_in,
  output logic        CU_A_in,
  output logic        CU_G_in,
  output logic        CU_AddSub,
  output logic        CU_ADDR_in,
  output logic        CU_DOUT_in,
  output logic        CU_W_D,
  output logic        CU_PC_incr,
  output logic        CU_Done
);

  typedef enum logic [2:0] {
    S_F0 = 3'd0,
    S_F1 = 3'd1,
    S_F2 = 3'd2,
    S_E1 = 3'd3,
    S_E2 = 3'd4,
    S_E3 = 3'd5
  } state_t;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_RX   = 4'b0001;
  localparam logic [3:0] SEL_RY   = 4'b0010;
  localparam logic [3:0] SEL_CNT  = 4'b0011;
  localparam logic [3:0] SEL_IMM  = 4'b0100;
  localparam logic [3:0] SEL_IMMT = 4'b0101;
  localparam logic [3:0] SEL_G    = 4'b0110;
  localparam logic [3:0] SEL_DIN  = 4'b0111;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_MVT  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_LD   = 4'b0101;
  localparam logic [3:0] OP_ST   = 4'b0110;
`ifdef CONTROL_UNIT_MVNZ_EN
  localparam logic [3:0] OP_MVNZ = 4'b0111;
`endif

  state_t      r_state;
  logic [3:0]  w_opcode;
  logic [7:0]  w_rx_onehot;
  logic [7:0]  w_unused_bits;

  assign w_opcode    = CU_IR[16:13];
  assign w_rx_onehot = 8'b0000_0001 << CU_IR[12:10];
  // IR bits [9:3] feed only the datapath immediate; G_nz matters only with MVNZ enabled.
  assign w_unused_bits = {CU_IR[9:3], CU_G_nz};

  // Output decode from state and IR; everything is forced low while reset is held.
  always_comb begin
    CU_MUX_select = SEL_NONE;
    CU_R_in       = 8'b0;
    CU_IR_in      = 1'b0;
    CU_A_in       = 1'b0;
    CU_G_in       = 1'b0;
    CU_AddSub     = 1'b0;
    CU_ADDR_in    = 1'b0;
    CU_DOUT_in    = 1'b0;
    CU_W_D        = 1'b0;
    CU_PC_incr    = 1'b0;
    CU_Done       = 1'b0;
    if (!Reset) begin
      case (r_state)
        S_F0: begin
          if (CU_Run) begin
            CU_MUX_select = SEL_CNT;
            CU_ADDR_in    = 1'b1;
          end
        end
        S_F1: CU_PC_incr = 1'b1;
        S_F2: begin
          CU_MUX_select = SEL_DIN;
          CU_IR_in      = 1'b1;
        end
        S_E1: begin
          case (w_opcode)
            OP_MV: begin
              CU_MUX_select = SEL_RY;
              CU_R_in       = w_rx_onehot;
              CU_Done       = 1'b1;
            end
            OP_MVI: begin
              CU_MUX_select = SEL_IMM;
              CU_R_in       = w_rx_onehot;
              CU_Done       = 1'b1;
            end
            OP_MVT: begin
              CU_MUX_select = SEL_IMMT;
              CU_R_in       = w_rx_onehot;
              CU_Done       = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              CU_MUX_select = SEL_RX;
              CU_A_in       = 1'b1;
            end
            OP_LD, OP_ST: begin
              CU_MUX_select = SEL_RY;
              CU_ADDR_in    = 1'b1;
            end
`ifdef CONTROL_UNIT_MVNZ_EN
            OP_MVNZ: begin
              CU_Done = 1'b1;
              if (CU_G_nz) begin
                CU_MUX_select = SEL_RY;
                CU_R_in       = w_rx_onehot;
              end
            end
`endif
            default: CU_Done = 1'b1;
          endcase
        end
        S_E2: begin
          case (w_opcode)
            OP_ADD, OP_SUB: begin
              CU_MUX_select = SEL_RY;
              CU_G_in       = 1'b1;
              CU_AddSub     = (w_opcode == OP_SUB);
            end
            OP_ST: begin
              CU_MUX_select = SEL_RX;
              CU_DOUT_in    = 1'b1;
              CU_W_D        = 1'b1;
              CU_Done       = 1'b1;
            end
            default: ;
          endcase
        end
        S_E3: begin
          CU_R_in = w_rx_onehot;
          CU_Done = 1'b1;
          if (w_opcode == OP_LD) CU_MUX_select = SEL_DIN;
          else                   CU_MUX_select = SEL_G;
        end
        default: ;
      endcase
    end
  end

  // State sequencing: any cycle that signals Done returns to F0 for the next fetch.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_F0;
    end else begin
      case (r_state)
        S_F0:    if (CU_Run) r_state <= S_F1;
        S_F1:    r_state <= S_F2;
        S_F2:    r_state <= S_E1;
        S_E1:    r_state <= CU_Done ? S_F0 : S_E2;
        S_E2:    r_state <= CU_Done ? S_F0 : S_E3;
        S_E3:    r_state <= S_F0;
        default: r_state <= S_F0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe tables built from opcode rules.
// Each cycle's outputs are compared at the falling edge against the table entry.
// Covers reset, directed instructions, back-to-back issue, mid-instruction reset and random streams.
module tb_control_unit;

  logic        Clock;
  logic        Reset;
  logic        CU_Run;
  logic [16:0] CU_IR;
  logic        CU_G_nz;
  logic [3:0]  CU_MUX_select;
  logic [7:0]  CU_R_in;
  logic        CU_IR_in, CU_A_in, CU_G_in, CU_AddSub;
  logic        CU_ADDR_in, CU_DOUT_in, CU_W_D, CU_PC_incr, CU_Done;

  int n_cmp = 0;
  int n_err = 0;

  control_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .CU_Run        (CU_Run),
    .CU_IR         (CU_IR),
    .CU_G_nz       (CU_G_nz),
    .CU_MUX_select (CU_MUX_select),
    .CU_R_in       (CU_R_in),
    .CU_IR_in      (CU_IR_in),
    .CU_A_in       (CU_A_in),
    .CU_G_in       (CU_G_in),
    .CU_AddSub     (CU_AddSub),
    .CU_ADDR_in    (CU_ADDR_in),
    .CU_DOUT_in    (CU_DOUT_in),
    .CU_W_D        (CU_W_D),
    .CU_PC_incr    (CU_PC_incr),
    .CU_Done       (CU_Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observed outputs packed as {sel, r_in, ir, a, g, addsub, addr, dout, wd, pc, done}.
  logic [20:0] w_obs;
  assign w_obs = {CU_MUX_select, CU_R_in, CU_IR_in, CU_A_in, CU_G_in, CU_AddSub,
                  CU_ADDR_in, CU_DOUT_in, CU_W_D, CU_PC_incr, CU_Done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] mk(input logic [3:0] sel, input logic [7:0] rin,
                                     input logic ir, input logic a, input logic g,
                                     input logic as, input logic addr, input logic dout,
                                     input logic wd, input logic pc, input logic done);
    return {sel, rin, ir, a, g, as, addr, dout, wd, pc, done};
  endfunction

  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'd3, 4'd4, 4'd5: return 6;
      4'd6:             return 5;
      default:          return 4;
    endcase
  endfunction

  // Expected outputs for cycle k (0 = F0 with Run) of an instruction.
  function automatic logic [20:0] exp_step(input logic [3:0] op, input int k,
                                           input logic [2:0] rx, input logic gnz);
    logic [7:0] oh;
    int e;
    oh = 8'd1 << rx;
    if (k == 0) return mk(4'd3, 8'd0, 0,0,0,0, 1,0,0,0, 0);
    if (k == 1) return mk(4'd0, 8'd0, 0,0,0,0, 0,0,0,1, 0);
    if (k == 2) return mk(4'd7, 8'd0, 1,0,0,0, 0,0,0,0, 0);
    e = k - 3;
    case (op)
      4'd0: return mk(4'd2, oh, 0,0,0,0, 0,0,0,0, 1);
      4'd1: return mk(4'd4, oh, 0,0,0,0, 0,0,0,0, 1);
      4'd2: return mk(4'd5, oh, 0,0,0,0, 0,0,0,0, 1);
      4'd3, 4'd4: begin
        if (e == 0) return mk(4'd1, 8'd0, 0,1,0,0, 0,0,0,0, 0);
        if (e == 1) return mk(4'd2, 8'd0, 0,0,1,(op == 4'd4), 0,0,0,0, 0);
        return mk(4'd6, oh, 0,0,0,0, 0,0,0,0, 1);
      end
      4'd5: begin
        if (e == 0) return mk(4'd2, 8'd0, 0,0,0,0, 1,0,0,0, 0);
        if (e == 1) return 21'd0;
        return mk(4'd7, oh, 0,0,0,0, 0,0,0,0, 1);
      end
      4'd6: begin
        if (e == 0) return mk(4'd2, 8'd0, 0,0,0,0, 1,0,0,0, 0);
        return mk(4'd1, 8'd0, 0,0,0,0, 0,1,1,0, 1);
      end
`ifdef CONTROL_UNIT_MVNZ_EN
      4'd7: begin
        if (gnz) return mk(4'd2, oh, 0,0,0,0, 0,0,0,0, 1);
        return mk(4'd0, 8'd0, 0,0,0,0, 0,0,0,0, 1);
      end
`endif
      default: return mk(4'd0, 8'd0, 0,0,0,0, 0,0,0,0, 1);
    endcase
  endfunction

  // Runs one instruction from F0, checking every cycle; stop_at>=0 truncates after that many cycles.
  // gmode: 0 force G_nz=0, 1 force G_nz=1, 2 random per cycle. Returns #1 after a rising edge.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [2:0] rx,
                           input logic [2:0] ry, input logic [8:0] imm, input int gmode,
                           input bit hold, input int stop_at);
    int n;
    logic [16:0] ir;
    ir = {op, rx, 1'($urandom_range(0, 1)), imm};
    ir[2:0] = ry;
    n = (stop_at >= 0) ? stop_at : instr_len(op);
    for (int k = 0; k < n; k++) begin
      CU_Run  = (k == 0 || hold) ? 1'b1 : 1'($urandom_range(0, 1));
      CU_G_nz = (gmode == 2) ? 1'($urandom_range(0, 1)) : (gmode == 1);
      if (k == 0) CU_IR = ir;
      @(negedge Clock);
      check($sformatf("%s_s%0d", tag, k), 32'(w_obs), 32'(exp_step(op, k, rx, CU_G_nz)));
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      CU_Run  = 1'b0;
      CU_G_nz = 1'($urandom_range(0, 1));
      CU_IR   = 17'($urandom);
      @(negedge Clock);
      check($sformatf("%s_idle%0d", tag, k), 32'(w_obs), 32'd0);
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    Reset   = 1'b1;
    CU_Run  = 1'b0;
    CU_IR   = 17'd0;
    CU_G_nz = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("reset_outs", 32'(w_obs), 32'd0);
    CU_Run = 1'b1;
    #1;
    check("reset_outs_run_hi", 32'(w_obs), 32'd0);
    CU_Run = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    idle_cycles("post_reset", 5);

    // Directed: MVI R3, 5
    run_instr("mvi", 4'd1, 3'd3, 3'd5, 9'h005, 0, 1'b0, -1);
    idle_cycles("gap1", 1);
    // Directed: SUB R2, R5
    run_instr("sub", 4'd4, 3'd2, 3'd5, 9'h000, 0, 1'b0, -1);
    // Directed: ST R1,[R4] then LD R6,[R4] back-to-back, Run held high
    run_instr("st", 4'd6, 3'd1, 3'd4, 9'h000, 0, 1'b1, -1);
    run_instr("ld", 4'd5, 3'd6, 3'd4, 9'h000, 0, 1'b1, -1);
    // R7 write via MV
    run_instr("mv_r7", 4'd0, 3'd7, 3'd2, 9'h000, 0, 1'b0, -1);

    // Reset pulsed during E2 of ADD
    run_instr("add_pre_rst", 4'd3, 3'd4, 3'd1, 9'h000, 0, 1'b1, 4);
    CU_Run = 1'b1;
    Reset  = 1'b1;
    #1;
    check("rst_mid_strobes", 32'(w_obs), 32'd0);
    @(negedge Clock);
    check("rst_mid_done", 32'(CU_Done), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    idle_cycles("post_mid_rst", 2);
    run_instr("mv_after_rst", 4'd0, 3'd5, 3'd3, 9'h000, 0, 1'b0, -1);

    // Opcode 0111 with Rx=0, both G_nz values
    run_instr("op7_gnz1", 4'd7, 3'd0, 3'd6, 9'h000, 1, 1'b0, -1);
    run_instr("op7_gnz0", 4'd7, 3'd0, 3'd6, 9'h000, 0, 1'b0, -1);
    // Invalid opcode
    run_instr("inv", 4'd12, 3'd3, 3'd1, 9'h000, 2, 1'b0, -1);

    // Random instruction stream with random idle gaps
    for (int i = 0; i < 150; i++) begin
      run_instr($sformatf("rnd%0d", i), 4'($urandom), 3'($urandom), 3'($urandom),
                9'($urandom), 2, 1'($urandom_range(0, 1)), -1);
      idle_cycles($sformatf("rnd%0d", i), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
